// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: state encoding, NOP encoding and default widths.
package cpu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ILEN_DEF  = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// IF/ID valid/ready register: load captures an entry, drain empties it once
// decode accepts, flush empties it unconditionally and wins over load.
module fetch_out_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ILEN  = ILEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pc,
  input  logic [ILEN-1:0]  load_instr,
  input  logic             load_fault,
  input  logic             drain,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [ILEN-1:0]  out_instr,
  output logic             out_fault
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      out_pc    <= '0;
      out_instr <= ILEN'(NOP);
      out_fault <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      out_pc    <= load_pc;
      out_instr <= load_instr;
      out_fault <= load_fault;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: one outstanding imem request, PC-counter enable,
// redirect handling with stale-response drop, misaligned-PC fault entries.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ILEN  = ILEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  input  logic             redirect,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [ILEN-1:0]  imem_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] id_pc,
  output logic [ILEN-1:0]  id_instr,
  output logic             id_fault
);

  fetch_state_e     state, state_nxt;
  logic [WIDTH-1:0] req_pc;
  logic             aligned, slot_free;
  logic             load, load_fault;
  logic [WIDTH-1:0] load_pc;
  logic [ILEN-1:0]  load_instr;

  assign aligned   = (pc[1:0] == 2'b00);
  assign slot_free = !id_valid || id_ready;
  assign imem_addr = pc;
  assign pc_en     = (imem_req && imem_gnt) || redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RST;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (imem_req && imem_gnt) req_pc <= pc;
    end
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    load       = 1'b0;
    load_pc    = req_pc;
    load_instr = imem_rdata;
    load_fault = 1'b0;
    case (state)
      S_RST: state_nxt = S_REQ;
      S_REQ: begin
        if (!redirect && slot_free) begin
          if (aligned) begin
            imem_req = 1'b1;
            if (imem_gnt) state_nxt = S_WAIT;
          end else begin
            // Fault entry; pc_en stays low so the stall persists until redirect.
            load       = 1'b1;
            load_pc    = pc;
            load_instr = ILEN'(NOP);
            load_fault = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = S_REQ;
          load      = !redirect;
        end else if (redirect) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_RST;
    endcase
  end

  fetch_out_reg #(
    .WIDTH(WIDTH),
    .ILEN (ILEN)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_pc   (load_pc),
    .load_instr(load_instr),
    .load_fault(load_fault),
    .drain     (id_ready),
    .flush     (redirect),
    .valid     (id_valid),
    .out_pc    (id_pc),
    .out_instr (id_instr),
    .out_fault (id_fault)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a
// transaction-level reference model with a PC counter and memory responder.
module tb_instr_fetch;

  localparam int W  = 32;
  localparam int IL = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  pc = '0;
  logic          pc_en;
  logic          redirect = 1'b0;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [IL-1:0] imem_rdata = '0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [W-1:0]  id_pc;
  logic [IL-1:0] id_instr;
  logic          id_fault;

  always #5 clk = ~clk;

  instr_fetch #(.WIDTH(W), .ILEN(IL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .pc_en      (pc_en),
    .redirect   (redirect),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_fault   (id_fault)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch bookkeeping, IF/ID contents, memory responder
  bit          armed, outst, stale;
  logic [31:0] req_addr;
  bit          mv, mfault;
  logic [31:0] mpc, minstr;
  logic [31:0] tgt = '0;
  int          mem_cnt = 0;
  logic [31:0] mem_data = '0;
  bit          rand_mode = 1'b0;
  int          lat_fixed = 1;
  bit          data_fixed = 1'b0;
  logic [31:0] data_val = '0;

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic step();
    bit m_al, m_slot, m_req, m_fld, m_pcen, resp;
    @(negedge clk);
    m_al   = (pc[1:0] == 2'b00);
    m_slot = !mv || id_ready;
    m_req  = armed && !outst && !redirect && m_slot && m_al;
    m_fld  = armed && !outst && !redirect && m_slot && !m_al;
    m_pcen = (m_req && imem_gnt) || redirect;
    check_eq("imem_req", imem_req, m_req);
    check_eq("pc_en", pc_en, m_pcen);
    check_eq("imem_addr", imem_addr, pc);
    check_eq("id_valid", id_valid, mv);
    if (mv) begin
      check_eq("id_pc", id_pc, mpc);
      check_eq("id_instr", id_instr, minstr);
      check_eq("id_fault", id_fault, mfault);
    end
    @(posedge clk);
    #1;
    resp = outst && imem_rvalid;
    if (redirect) mv = 1'b0;
    else if (resp && !stale) begin
      mv = 1'b1; mpc = req_addr; minstr = imem_rdata; mfault = 1'b0;
    end else if (m_fld) begin
      mv = 1'b1; mpc = pc; minstr = 32'h00000013; mfault = 1'b1;
    end else if (mv && id_ready) mv = 1'b0;
    if (resp) outst = 1'b0;
    else if (outst && redirect) stale = 1'b1;
    if (m_req && imem_gnt) begin
      outst    = 1'b1;
      stale    = 1'b0;
      req_addr = pc;
      mem_cnt  = rand_mode ? $urandom_range(1, 3) : lat_fixed;
      mem_data = data_fixed ? data_val : $urandom;
    end
    if (redirect) pc = tgt;
    else if (m_pcen) pc = pc + 32'd4;
    armed = 1'b1;
    if (mem_cnt > 0) begin
      mem_cnt--;
      imem_rvalid = (mem_cnt == 0);
    end else imem_rvalid = 1'b0;
    imem_rdata = imem_rvalid ? mem_data : $urandom;
    if (rand_mode) begin
      imem_gnt = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 15) == 0);
      tgt      = rand_target();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_imem_req"}, imem_req, 1'b0);
    check_eq({tag, "_pc_en"}, pc_en, 1'b0);
    check_eq({tag, "_id_valid"}, id_valid, 1'b0);
    check_eq({tag, "_id_fault"}, id_fault, 1'b0);
    check_eq({tag, "_id_pc"}, id_pc, 32'h0);
    check_eq({tag, "_id_instr"}, id_instr, 32'h00000013);
  endtask

  // Reset held across two edges; a late response strobe arrives while in reset.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    armed = 1'b0; outst = 1'b0; stale = 1'b0; mv = 1'b0;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    check_reset_outputs("rst_hold");
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    mem_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_outstanding(input string tag);
    for (int i = 0; i < 20 && !outst; i++) step();
    check_eq(tag, outst, 1'b1);
  endtask

  initial begin
    #2;
    // Basic fetch: pc=0, immediate grant, k=1
    pc = 32'h0; imem_gnt = 1'b1; id_ready = 1'b1; lat_fixed = 1;
    data_fixed = 1'b1; data_val = 32'h00500093;
    do_reset();
    repeat (3) step();
    check_eq("basic_valid", id_valid, 1'b1);
    check_eq("basic_pc", id_pc, 32'h0);
    check_eq("basic_instr", id_instr, 32'h00500093);
    check_eq("basic_next_addr", imem_addr, 32'h4);
    check_eq("basic_next_req", imem_req, 1'b1);
    repeat (6) step();
    data_fixed = 1'b0;

    // Decode stall with an entry held
    id_ready = 1'b0;
    for (int i = 0; i < 20 && !mv; i++) step();
    check_eq("stall_entry", mv, 1'b1);
    repeat (5) step();
    check_eq("stall_no_req", imem_req, 1'b0);
    id_ready = 1'b1;
    repeat (4) step();

    // Redirect while waiting on a k=3 response
    lat_fixed = 3;
    wait_outstanding("redir_wait_grant");
    redirect = 1'b1; tgt = 32'h100;
    step();
    redirect = 1'b0;
    repeat (8) step();

    // Redirect coincident with the response strobe
    lat_fixed = 2;
    wait_outstanding("redir_rv_grant");
    for (int i = 0; i < 20 && !imem_rvalid; i++) step();
    check_eq("redir_rv_seen", imem_rvalid, 1'b1);
    redirect = 1'b1; tgt = 32'h200;
    step();
    redirect = 1'b0;
    repeat (6) step();

    // Misaligned PC stall until redirect
    lat_fixed = 1;
    redirect = 1'b1; tgt = 32'h6;
    step();
    redirect = 1'b0;
    repeat (8) step();
    check_eq("mis_valid", id_valid, 1'b1);
    check_eq("mis_pc", id_pc, 32'h6);
    check_eq("mis_instr", id_instr, 32'h00000013);
    check_eq("mis_fault", id_fault, 1'b1);
    check_eq("mis_pc_en", pc_en, 1'b0);
    check_eq("mis_req", imem_req, 1'b0);
    redirect = 1'b1; tgt = 32'h8;
    step();
    redirect = 1'b0;
    repeat (6) step();

    // Reset one cycle after a grant
    lat_fixed = 3;
    wait_outstanding("rst_wait_grant");
    do_reset();
    repeat (8) step();

    // Randomized traffic
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    redirect = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage directly downstream of the PC counter. Takes the current PC, issues one instruction-memory request at a time, drives the PC register enable so the counter advances only once a fetch is granted, and presents the fetched instruction with its PC to decode through a valid/ready IF/ID register. It also handles redirects (branch/jump) by discarding stale in-flight responses, and flags misaligned PCs.

## Interface
Parameters:
- WIDTH, 32, PC/address width
- ILEN, 32, instruction width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- pc  in  WIDTH  current PC from the counter
- pc_en  out  1  enable to the PC register: high on accepted grant or on redirect
- redirect  in  1  branch/jump taken this cycle; the counter loads its new PC at this edge
- imem_req  out  1  memory request valid
- imem_addr  out  WIDTH  request address (= pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  one-cycle response strobe
- imem_rdata  in  ILEN  response instruction
- id_valid  out  1  IF/ID entry valid
- id_ready  in  1  decode accepts the entry
- id_pc  out  WIDTH  PC of the entry
- id_instr  out  ILEN  instruction; NOP 32'h00000013 when id_fault
- id_fault  out  1  entry is a misaligned-PC fault (pc[1:0] != 0)

## Operation
- States: RST, REQ, WAIT, DROP.
- RST: entered on reset; leaves for REQ on the first clock after rst_n is released.
- REQ: imem_req = !redirect && pc[1:0]==0 && slot_free, where slot_free = !id_valid || id_ready. On req && imem_gnt: latch req_pc = pc, pulse pc_en, go to WAIT. If pc is misaligned, slot_free holds, and redirect is low: no request; load the IF/ID register with {pc, NOP, fault=1}; stay in REQ; pc_en stays low, so the stall holds until redirect.
- WAIT: on imem_rvalid, load IF/ID with {req_pc, imem_rdata, fault=0} and go to REQ. On redirect without rvalid, go to DROP. On redirect together with rvalid, discard the data and go to REQ.
- DROP: wait for imem_rvalid, discard it, then go to REQ. Redirect in DROP has no further effect.
- Only one request is outstanding at a time. A request is issued only when the slot is free, so the IF/ID register is guaranteed empty when the response arrives. No skid buffer is needed.
- IF/ID register: loads as above. It clears (id_valid=0) on id_valid && id_ready with no new load, and always clears on redirect. Redirect has priority over any load in the same cycle.
- pc_en = (imem_req && imem_gnt) | redirect.

## Timing
- Reset (async): state=RST, imem_req=0, pc_en=0, id_valid=0, id_fault=0, id_pc=0, id_instr=NOP.
- imem_req, imem_addr, and pc_en are combinational from state and inputs. All id_* outputs are registered.
- Request granted at cycle t → counter shows pc+4 at t+1. Response rvalid at t+k (k≥1) → id_valid at t+k+1. The next request can issue at t+k+1 at the earliest.
- Back-to-back with k=1 and id_ready tied high: one instruction every 2 cycles.
- Decode stall: id_valid and its data are held stable until id_ready is sampled high. No new request is issued while the slot is occupied and not draining.
- imem_gnt is ignored outside REQ. imem_rvalid is ignored in REQ and RST.

## Structure
- Shared package cpu_pkg holds:
  - the fetch state enum (RST, REQ, WAIT, DROP)
  - the NOP constant 32'h00000013
  - the default WIDTH/ILEN.
- One sub-module, fetch_out_reg: the IF/ID valid/ready register with load, drain, and flush inputs. It has its own async active-low reset.
- The FSM, req_pc latch, and request/enable logic live in instr_fetch.

## Test plan
- Reset mid-WAIT (rst_n low one cycle after a grant) → all outputs at reset values immediately; after release, the first request has imem_addr = current pc, and the late rvalid arriving in RST is ignored.
- pc=0x0, gnt immediate, rvalid k=1 with rdata 0x00500093, id_ready=1 → pc_en pulses once; id_valid at cycle 3 with id_pc=0x0, id_instr=0x00500093; next imem_addr=0x4.
- id_ready=0 for 5 cycles with an entry held → no imem_req and no pc_en during the stall; id_* stable; on id_ready=1, a request issues the same cycle.
- Redirect in WAIT (rvalid k=3) → state DROP, id_valid=0, the response is discarded; the next request uses the redirected pc; no spurious entry reaches decode.
- Redirect coincident with rvalid → data discarded, state REQ next cycle, pc_en=1 that cycle, id_valid stays 0.
- pc=0x6 → no imem_req; entry {0x6, 0x00000013, fault=1}; pc_en stays low until redirect.
